mips_multicycle_core: RTL
=========================

// Module: mips_multicycle_core
// PURPOSE
//  Multi-cycle MIPS-subset core; successor to the single-cycle top. One FSM shares a single ALU and one unified
//  instruction/data memory port with a req/ready handshake, so slow or shared memories are supported.
//  Contains PC, IR, MDR, A/B/ALUOut registers, a 32x32 register file and a debug read port.
//  Sits between the system memory/arbiter and the display/selector logic.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  ADDR_W     32             width of mem_addr; the PC stays 32 bit, and mem_addr = PC/ALUOut[ADDR_W-1:0]
//  HALT_OP    6'h3F          opcode that stops the core cleanly
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high reset
//  mem_req    out  1       memory transfer request
//  mem_we     out  1       1 = write (sw); 0 = read (fetch or lw)
//  mem_addr   out  ADDR_W  byte address, word-aligned
//  mem_wdata  out  32      store data (B register)
//  mem_rdata  in   32      read data; valid in the cycle where mem_req && mem_ready
//  mem_ready  in   1       transfer completes on the cycle where mem_req && mem_ready
//  retire     out  1       1-cycle pulse on the final cycle of each completed instruction
//  halted     out  1       sticky; core stopped
//  illegal    out  1       sticky; the halt was caused by a fault
//  pc_out     out  32      current PC register
//  dbg_sel    in   5       register index for the debug read
//  dbg_data   out  32      combinational regfile[dbg_sel]; 0 when dbg_sel == 0
// BEHAVIOUR
//  Reset (sampled on clk edge):
//   PC = RESET_PC; state = FETCH; regfile, IR, MDR, A, B, ALUOut = 0; retire, halted, illegal = 0.
//   While reset is high, mem_req is forced to 0.
//   Reset during a pending transfer abandons it; the first post-reset cycle requests a fetch at RESET_PC.
//  States and transitions:
//   FETCH: mem_req=1, mem_we=0, addr=PC. On ready: IR = rdata, PC = PC+4, go to DECODE. Otherwise stay, outputs stable.
//   DECODE: A=rs, B=rt, ALUOut = PC + (sext(imm)<<2). Then, by opcode:
//    - 00 R-type, 08 addi, 23 lw, 2B sw: go to EXEC.
//    - 04 beq, 02 j: go to BRJ.
//    - HALT_OP: go to HALT.
//    - anything else: go to HALT with illegal=1.
//   BRJ: beq taken (A==B): PC = ALUOut. j: PC = {PC[31:28], IR[25:0], 2'b00}. retire, then go to FETCH.
//   EXEC:
//    - R-type: ALUOut = A op B. funct 20 add, 22 sub, 24 and, 25 or, 2A slt (signed). Other funct -> HALT, illegal.
//    - addi/lw/sw: ALUOut = A + sext(imm).
//    - lw/sw with ALUOut[1:0] != 0 -> HALT, illegal, no memory access.
//   MEM: mem_req=1, addr=ALUOut, we=(sw), wdata=B. On ready: lw latches MDR and goes to WB; sw retires and goes to FETCH.
//   WB: rd (R-type) or rt (addi/lw) = ALUOut or MDR. retire, then go to FETCH.
//   HALT: mem_req=0; stays here until reset.
//  Handshake:
//   - While mem_req=1 and ready=0, addr/we/wdata are held unchanged.
//   - ready is ignored when req=0.
//   - ready may be high in the same cycle as req (zero-wait).
//  Zero-wait cycle counts: R/addi 4, lw 5, sw 4, beq/j 3. Each wait cycle adds 1.
//  Register file:
//   - Writes to $0 are dropped; $0 always reads 0.
//   - Reads in DECODE see writes retired by earlier instructions.
//  Arithmetic: modulo 2^32, no overflow traps. PC wraps modulo 2^32.
// TESTING
//  1 Reset, zero-wait memory, 0x20010005 (addi $1,$0,5) -> retire in cycle 4; dbg_sel=1 gives 5; pc_out=4.
//  2 lw $2,8($0) with mem_ready low 3 cycles in MEM -> addr=8 held 4 cycles; $2=MDR; retire at cycle 8.
//  3 $1=$2=7, beq at PC 0x10 with offset -2 -> pc_out=0x0C after 3 cycles.
//    $1!=$2 -> pc_out=0x14.
//  4 j with target 0x40 at PC 0x0 -> pc_out=0x100.
//    sw with misaligned addr 0x6 -> halted=1, illegal=1, no mem_we pulse.
//  5 sub $3,$0,$1 with $1=1 -> 0xFFFFFFFF. slt -1 < 1 -> 1. add into $0 -> dbg_sel=0 reads 0.
//  6 0xFC000000 (HALT_OP) -> halted=1, illegal=0, mem_req stays 0.
//    Reset asserted mid-FETCH wait -> next request at RESET_PC, halted cleared.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one FSM drives a shared ALU and a single unified
// instruction/data memory port with a req/ready handshake.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       pc_out,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRJ    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic        halted_q, halted_d, illegal_q, illegal_d;
  logic [31:0] regfile_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_c;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext, addr_sum;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign addr_sum = a_q + imm_sext;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    retire_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regfile_q[rs];
        b_d   = regfile_q[rt];
        alu_d = pc_q + {imm_sext[29:0], 2'b00};
        if (opcode == OP_RTYPE || opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_EXEC;
        end else if (opcode == OP_BEQ || opcode == OP_J) begin
          state_d = S_BRJ;
        end else begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = (opcode != HALT_OP);
        end
      end
      S_BRJ: begin
        if (opcode == OP_BEQ && a_q == b_q) pc_d = alu_q;
        else if (opcode == OP_J) pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        if (opcode == OP_RTYPE) begin
          state_d = S_WB;
          case (funct)
            6'h20:   alu_d = a_q + b_q;
            6'h22:   alu_d = a_q - b_q;
            6'h24:   alu_d = a_q & b_q;
            6'h25:   alu_d = a_q | b_q;
            6'h2A:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
            default: begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end else begin
          alu_d = addr_sum;
          // Misaligned lw/sw faults here so the memory port never sees it.
          if (opcode != OP_ADDI && addr_sum[1:0] != 2'b00) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // $0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regfile_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regfile_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req   = !reset && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = mem_req && (state_q == S_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign retire    = retire_c && !reset;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : regfile_q[dbg_sel];

endmodule
